// File: rtl/udp_rx_stream.sv
// UDP receive path: strips the 8-byte UDP header from an AXI stream, presents it
// on a header handshake, and forwards the payload through a single output register.
module udp_rx_stream #(
    parameter int AXI_DATA_WIDTH = 8,
    parameter int KEEP_WIDTH     = AXI_DATA_WIDTH / 8,
    parameter bit PORT_FILTER    = 1'b0
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_trdy,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    input  logic                      m_axis_trdy,
    output logic                      m_udp_hdr_tvalid,
    input  logic                      m_udp_hdr_trdy,
    output logic [15:0]               m_udp_src_port,
    output logic [15:0]               m_udp_dst_port,
    output logic [15:0]               m_udp_length,
    output logic [15:0]               m_udp_checksum,
    input  logic [15:0]               i_local_port,
    output logic                      o_err_truncated,
    output logic                      o_err_length
);
    localparam int BPB = AXI_DATA_WIDTH / 8;
    localparam int HDR_BEATS = 64 / AXI_DATA_WIDTH;
    localparam logic [3:0] LAST_BEAT = 4'(HDR_BEATS - 1);

    typedef enum logic [1:0] {ST_HDR, ST_PAYLOAD, ST_DROP} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                beat_q, beat_d;
    logic [7:0]                hdr_q [8];
    logic [7:0]                hdr_d [8];
    logic                      hdr_valid_q, hdr_valid_d;
    logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
    logic [KEEP_WIDTH-1:0]     keep_q, keep_d;
    logic                      last_q, last_d;
    logic                      user_q, user_d;
    logic                      valid_q, valid_d;
    logic [15:0]               cnt_q, cnt_d;
    logic                      err_trunc_q, err_trunc_d;
    logic                      err_len_q, err_len_d;

    logic        s_rdy, accept, filt_ok, len_bad;
    logic [15:0] beat_bytes, total, cur_len, new_len, new_dst;

    assign s_axis_trdy      = s_rdy;
    assign accept           = s_axis_tvalid && s_rdy;
    assign m_axis_tdata     = data_q;
    assign m_axis_tkeep     = keep_q;
    assign m_axis_tvalid    = valid_q;
    assign m_axis_tlast     = last_q;
    assign m_axis_tuser     = user_q;
    assign m_udp_hdr_tvalid = hdr_valid_q;
    assign m_udp_src_port   = {hdr_q[0], hdr_q[1]};
    assign m_udp_dst_port   = {hdr_q[2], hdr_q[3]};
    assign m_udp_length     = {hdr_q[4], hdr_q[5]};
    assign m_udp_checksum   = {hdr_q[6], hdr_q[7]};
    assign o_err_truncated  = err_trunc_q;
    assign o_err_length     = err_len_q;

    assign cur_len = {hdr_q[4], hdr_q[5]};
    assign new_len = {hdr_d[4], hdr_d[5]};
    assign new_dst = {hdr_d[2], hdr_d[3]};
    assign filt_ok = !PORT_FILTER || (new_dst == i_local_port);
    assign total   = cnt_q + beat_bytes;
    // Lengths below 8 can never be satisfied, even if the wrapped subtraction matches.
    assign len_bad = (total != cur_len - 16'd8) || (cur_len < 16'd8);

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            beat_bytes = beat_bytes + 16'(s_axis_tkeep[i]);
        end
    end

    always_comb begin
        s_rdy = 1'b1;
        case (state_q)
            ST_HDR:     s_rdy = !hdr_valid_q;
            ST_PAYLOAD: s_rdy = !valid_q || m_axis_trdy;
            default:    s_rdy = 1'b1;
        endcase
    end

    // Merge the current beat into the header bytes so the final beat sees complete fields.
    always_comb begin
        hdr_d = hdr_q;
        if (state_q == ST_HDR && accept) begin
            for (int l = 0; l < BPB; l++) begin
                hdr_d[3'(int'(beat_q) * BPB + l)] = s_axis_tdata[l*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        hdr_valid_d = hdr_valid_q && !m_udp_hdr_trdy;
        data_d      = data_q;
        keep_d      = keep_q;
        last_d      = last_q;
        user_d      = user_q;
        valid_d     = valid_q && !m_axis_trdy;
        cnt_d       = cnt_q;
        err_trunc_d = 1'b0;
        err_len_d   = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        cnt_d  = '0;
                        if (!filt_ok) begin
                            state_d = s_axis_tlast ? ST_HDR : ST_DROP;
                        end else begin
                            hdr_valid_d = 1'b1;
                            if (s_axis_tlast) begin
                                err_len_d = (new_len != 16'd8);
                            end else begin
                                state_d = ST_PAYLOAD;
                            end
                        end
                    end else if (s_axis_tlast) begin
                        beat_d      = '0;
                        err_trunc_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    data_d  = s_axis_tdata;
                    keep_d  = s_axis_tkeep;
                    last_d  = s_axis_tlast;
                    valid_d = 1'b1;
                    user_d  = s_axis_tlast && len_bad;
                    cnt_d   = total;
                    if (s_axis_tlast) begin
                        err_len_d = len_bad;
                        cnt_d     = '0;
                        state_d   = ST_HDR;
                    end
                end
            end
            ST_DROP: begin
                if (accept && s_axis_tlast) begin
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_HDR;
            beat_q      <= '0;
            hdr_q       <= '{default: '0};
            hdr_valid_q <= 1'b0;
            data_q      <= '0;
            keep_q      <= '0;
            last_q      <= 1'b0;
            user_q      <= 1'b0;
            valid_q     <= 1'b0;
            cnt_q       <= '0;
            err_trunc_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            last_q      <= last_d;
            user_q      <= user_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            err_trunc_q <= err_trunc_d;
            err_len_q   <= err_len_d;
        end
    end
endmodule

// File: tb/tb_udp_rx_stream.sv
// Bench for udp_rx_stream: byte-wide filtered instance driven from a vector table and
// random back-to-back packets, plus a 32-bit instance for partial-keep payloads.
module tb_udp_rx_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [7:0]  s_tdata;
    logic [0:0]  s_tkeep;
    logic        s_tvalid, s_tlast, s_trdy;
    logic [7:0]  m_tdata;
    logic [0:0]  m_tkeep;
    logic        m_tvalid, m_tlast, m_tuser, m_trdy;
    logic        h_tvalid, h_trdy;
    logic [15:0] h_src, h_dst, h_len, h_csum, lport;
    logic        e_trunc, e_len;

    logic [31:0] s32_tdata, m32_tdata;
    logic [3:0]  s32_tkeep, m32_tkeep;
    logic        s32_tvalid, s32_tlast, s32_trdy;
    logic        m32_tvalid, m32_tlast, m32_tuser, m32_trdy;
    logic        h32_tvalid, h32_trdy;
    logic [15:0] h32_src, h32_dst, h32_len, h32_csum, lport32;
    logic        e32_trunc, e32_len;

    udp_rx_stream #(.AXI_DATA_WIDTH(8), .PORT_FILTER(1'b1)) dut (
        .i_clk(clk), .i_reset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_trdy(s_trdy),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_trdy(m_trdy),
        .m_udp_hdr_tvalid(h_tvalid), .m_udp_hdr_trdy(h_trdy),
        .m_udp_src_port(h_src), .m_udp_dst_port(h_dst),
        .m_udp_length(h_len), .m_udp_checksum(h_csum),
        .i_local_port(lport), .o_err_truncated(e_trunc), .o_err_length(e_len)
    );

    udp_rx_stream #(.AXI_DATA_WIDTH(32), .PORT_FILTER(1'b0)) dut32 (
        .i_clk(clk), .i_reset(rst),
        .s_axis_tdata(s32_tdata), .s_axis_tkeep(s32_tkeep), .s_axis_tvalid(s32_tvalid),
        .s_axis_tlast(s32_tlast), .s_axis_trdy(s32_trdy),
        .m_axis_tdata(m32_tdata), .m_axis_tkeep(m32_tkeep), .m_axis_tvalid(m32_tvalid),
        .m_axis_tlast(m32_tlast), .m_axis_tuser(m32_tuser), .m_axis_trdy(m32_trdy),
        .m_udp_hdr_tvalid(h32_tvalid), .m_udp_hdr_trdy(h32_trdy),
        .m_udp_src_port(h32_src), .m_udp_dst_port(h32_dst),
        .m_udp_length(h32_len), .m_udp_checksum(h32_csum),
        .i_local_port(lport32), .o_err_truncated(e32_trunc), .o_err_length(e32_len)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    typedef struct packed {logic [15:0] src, dst, len, csum;} hdr_t;
    typedef struct packed {logic [7:0] data; logic last; logic user;} beat_t;
    typedef struct packed {logic [31:0] d; logic [3:0] k; logic l; logic u;} beat32_t;

    hdr_t    exp_hdr_q[$];
    beat_t   exp_beat_q[$];
    beat32_t obs32_q[$];
    int exp_el = 0, exp_et = 0, obs_el = 0, obs_et = 0;
    int h32_cnt = 0, obs32_el = 0, obs32_et = 0;
    hdr_t h32_seen;
    logic drv_hdr = 1'b0;
    logic bp_en = 1'b0;
    logic gap_en = 1'b0;

    // Output monitor for the byte-wide instance: scoreboard pops, hold checks, pulse counts.
    logic       stall_prev = 1'b0, hstall_prev = 1'b0;
    logic [9:0] prev_out;
    hdr_t       prev_hdr;
    always @(negedge clk) begin
        hdr_t  eh;
        beat_t eb;
        if (!rst) begin
            if (h_tvalid && h_trdy) begin
                if (exp_hdr_q.size() == 0) begin
                    check("hdr_unexpected", 64'(1), 64'(0));
                end else begin
                    eh = exp_hdr_q.pop_front();
                    check("hdr_fields", {h_src, h_dst, h_len, h_csum}, eh);
                end
            end
            if (m_tvalid && m_trdy) begin
                if (exp_beat_q.size() == 0) begin
                    check("beat_unexpected", 64'(1), 64'(0));
                end else begin
                    eb = exp_beat_q.pop_front();
                    check("payload_beat", 64'({m_tdata, m_tlast, m_tuser, m_tkeep}), 64'({eb, 1'b1}));
                end
            end
            if (stall_prev) check("payload_hold", 64'({m_tvalid, m_tdata, m_tlast, m_tuser}), 64'({1'b1, prev_out}));
            if (hstall_prev) check("hdr_hold", 64'({h_tvalid, h_src, h_dst, h_len, h_csum}) , 64'({1'b1, prev_hdr}));
            stall_prev  = m_tvalid && !m_trdy;
            prev_out    = {m_tdata, m_tlast, m_tuser};
            hstall_prev = h_tvalid && !h_trdy;
            prev_hdr    = {h_src, h_dst, h_len, h_csum};
            if (s_tvalid && s_trdy && drv_hdr) check("hdr_accept_while_pending", 64'(h_tvalid), 64'(0));
            if (e_len) obs_el++;
            if (e_trunc) obs_et++;
        end else begin
            stall_prev  = 1'b0;
            hstall_prev = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m32_tvalid && m32_trdy) obs32_q.push_back({m32_tdata, m32_tkeep, m32_tlast, m32_tuser});
            if (h32_tvalid && h32_trdy) begin
                h32_cnt++;
                h32_seen = {h32_src, h32_dst, h32_len, h32_csum};
            end
            if (e32_len) obs32_el++;
            if (e32_trunc) obs32_et++;
        end
    end

    initial begin
        m_trdy = 1'b1;
        h_trdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                m_trdy = ($urandom_range(0, 3) != 0);
                h_trdy = ($urandom_range(0, 4) == 0);
            end else begin
                m_trdy = 1'b1;
                h_trdy = 1'b1;
            end
        end
    end

    function automatic logic [7:0] hdr_byte(input hdr_t h, input int i);
        logic [63:0] w;
        w = h;
        return w[63 - i*8 -: 8];
    endfunction

    function automatic logic [7:0] pay_byte(input int base, input int j);
        return 8'(base + j * 7);
    endfunction

    // Reference: what one packet should produce, straight from the packet rules.
    function automatic void model(input hdr_t h, input logic [15:0] lp, input int n, input int trunc,
                                  output bit xh, output bit xu, output int xel, output int xet);
        int want;
        xh = 1'b0; xu = 1'b0; xel = 0; xet = 0;
        want = int'(h.len) - 8;
        if (trunc >= 0) begin
            xet = 1;
        end else if (h.dst == lp) begin
            xh = 1'b1;
            if (n == 0) begin
                xel = (h.len != 16'd8) ? 1 : 0;
            end else begin
                xu  = (n != want);
                xel = xu ? 1 : 0;
            end
        end
    endfunction

    task automatic push_expect(input hdr_t h, input int n, input int base,
                               input bit xh, input bit xu, input int xel, input int xet);
        if (xh) begin
            exp_hdr_q.push_back(h);
            for (int j = 0; j < n; j++)
                exp_beat_q.push_back({pay_byte(base, j), (j == n - 1), xu && (j == n - 1)});
        end
        exp_el += xel;
        exp_et += xet;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input bit is_hdr);
        int waited = 0;
        s_tdata = d; s_tlast = last; s_tvalid = 1'b1; drv_hdr = is_hdr;
        @(negedge clk);
        while (!s_trdy && waited < 500) begin
            waited++;
            @(negedge clk);
        end
        if (!s_trdy) check("input_accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        s_tvalid = 1'b0; drv_hdr = 1'b0;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_packet(input hdr_t h, input logic [15:0] lp, input int n, input int trunc, input int base);
        lport = lp;
        for (int i = 0; i < 8; i++) begin
            send_byte(hdr_byte(h, i), (i == trunc) || (i == 7 && n == 0), 1'b1);
            if (i == trunc) return;
        end
        for (int j = 0; j < n; j++) send_byte(pay_byte(base, j), j == n - 1, 1'b0);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((exp_hdr_q.size() != 0 || exp_beat_q.size() != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (10) @(posedge clk);
        #1;
        check({tag, "_hdr_left"}, 64'(exp_hdr_q.size()), 64'(0));
        check({tag, "_beats_left"}, 64'(exp_beat_q.size()), 64'(0));
        check({tag, "_err_length_cnt"}, 64'(obs_el), 64'(exp_el));
        check({tag, "_err_trunc_cnt"}, 64'(obs_et), 64'(exp_et));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_s_trdy"}, 64'(s_trdy), 64'(1));
        check({tag, "_outputs"}, 64'({m_tvalid, m_tlast, m_tuser, m_tdata, m_tkeep, h_tvalid, e_trunc, e_len}), 64'(0));
        check({tag, "_hdr_fields"}, {h_src, h_dst, h_len, h_csum}, 64'(0));
    endtask

    task automatic send32(input logic [31:0] d, input logic [3:0] k, input bit last);
        int waited = 0;
        s32_tdata = d; s32_tkeep = k; s32_tlast = last; s32_tvalid = 1'b1;
        @(negedge clk);
        while (!s32_trdy && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!s32_trdy) check("w32_accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        s32_tvalid = 1'b0;
    endtask

    typedef struct {
        hdr_t        h;
        logic [15:0] lp;
        int          n;
        int          trunc;
        bit          xh;
        bit          xu;
        int          xel;
        int          xet;
    } vec_t;

    vec_t vt[11];

    initial begin
        hdr_t h;
        bit   xh, xu;
        int   xel, xet, n, trunc;
        logic [15:0] lp;

        vt[0]  = '{{16'h1234, 16'h5678, 16'h000C, 16'hABCD}, 16'h5678, 4, -1, 1'b1, 1'b0, 0, 0};
        vt[1]  = '{{16'h1234, 16'h5678, 16'h0010, 16'h0001}, 16'h5678, 6, -1, 1'b1, 1'b1, 1, 0};
        vt[2]  = '{{16'h2222, 16'h1111, 16'h000C, 16'h0002}, 16'h5678, 4, -1, 1'b0, 1'b0, 0, 0};
        vt[3]  = '{{16'h3333, 16'h5678, 16'h000B, 16'h0003}, 16'h5678, 3, -1, 1'b1, 1'b0, 0, 0};
        vt[4]  = '{{16'h4444, 16'h5678, 16'h000C, 16'h0004}, 16'h5678, 4, 5,  1'b0, 1'b0, 0, 1};
        vt[5]  = '{{16'h5555, 16'h5678, 16'h000A, 16'h0005}, 16'h5678, 2, -1, 1'b1, 1'b0, 0, 0};
        vt[6]  = '{{16'h6666, 16'h5678, 16'h0008, 16'h0006}, 16'h5678, 0, -1, 1'b1, 1'b0, 0, 0};
        vt[7]  = '{{16'h7777, 16'h5678, 16'h0009, 16'h0007}, 16'h5678, 0, -1, 1'b1, 1'b0, 1, 0};
        vt[8]  = '{{16'h8888, 16'h5678, 16'h0007, 16'h0008}, 16'h5678, 1, -1, 1'b1, 1'b1, 1, 0};
        vt[9]  = '{{16'h9999, 16'h5678, 16'h000C, 16'h0009}, 16'h5678, 4, 0,  1'b0, 1'b0, 0, 1};
        vt[10] = '{{16'hAAAA, 16'h5678, 16'h000C, 16'h000A}, 16'h5678, 4, 6,  1'b0, 1'b0, 0, 1};

        rst = 1'b1;
        s_tdata = '0; s_tkeep = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; lport = '0;
        s32_tdata = '0; s32_tkeep = '0; s32_tvalid = 1'b0; s32_tlast = 1'b0;
        m32_trdy = 1'b1; h32_trdy = 1'b1; lport32 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;

        bp_en = 1'b1;
        foreach (vt[i]) begin
            push_expect(vt[i].h, vt[i].n, i * 16, vt[i].xh, vt[i].xu, vt[i].xel, vt[i].xet);
            send_packet(vt[i].h, vt[i].lp, vt[i].n, vt[i].trunc, i * 16);
            drain($sformatf("vec%0d", i));
        end

        gap_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            lp    = 16'($urandom);
            n     = $urandom_range(0, 12);
            trunc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
            h.src = 16'($urandom);
            h.dst = ($urandom_range(0, 3) != 0) ? lp : 16'($urandom);
            h.len = ($urandom_range(0, 1) != 0) ? 16'(n + 8) : 16'($urandom_range(0, 24));
            h.csum = 16'($urandom);
            model(h, lp, n, trunc, xh, xu, xel, xet);
            push_expect(h, n, 100 + k * 13, xh, xu, xel, xet);
            send_packet(h, lp, n, trunc, 100 + k * 13);
        end
        drain("random");
        gap_en = 1'b0;

        // Reset in the middle of a payload, then a fresh packet must parse from byte 0.
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        h = '{16'h0A0B, 16'h5678, 16'h0010, 16'h0001};
        lport = 16'h5678;
        exp_hdr_q.push_back(h);
        for (int j = 0; j < 3; j++) exp_beat_q.push_back({pay_byte(200, j), 1'b0, 1'b0});
        for (int i = 0; i < 8; i++) send_byte(hdr_byte(h, i), 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) send_byte(pay_byte(200, j), 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_drained", 64'(exp_hdr_q.size() + exp_beat_q.size()), 64'(0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        @(posedge clk);
        #1;
        h = '{16'hBEEF, 16'h5678, 16'h000B, 16'h1357};
        model(h, 16'h5678, 3, -1, xh, xu, xel, xet);
        push_expect(h, 3, 220, xh, xu, xel, xet);
        send_packet(h, 16'h5678, 3, -1, 220);
        drain("post_reset");

        // 32-bit lanes: 2 header words, then 4 + 1 payload bytes.
        send32(32'h4D3C2B1A, 4'hF, 1'b0);
        send32(32'hF1E00D00, 4'hF, 1'b0);
        send32(32'h44332211, 4'hF, 1'b0);
        send32(32'h00000055, 4'h1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("w32_hdr_count", 64'(h32_cnt), 64'(1));
        check("w32_hdr_fields", h32_seen, 64'h1A2B_3C4D_000D_E0F1);
        check("w32_beat_count", 64'(obs32_q.size()), 64'(2));
        if (obs32_q.size() >= 2) begin
            check("w32_beat0", 64'(obs32_q[0]), 64'({32'h44332211, 4'hF, 1'b0, 1'b0}));
            check("w32_beat1", 64'(obs32_q[1]), 64'({32'h00000055, 4'h1, 1'b1, 1'b0}));
        end
        check("w32_err_pulses", 64'(obs32_el + obs32_et), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/udp_rx_stream.md
UDP_RX_STREAM -- requirements
Module: udp_rx_stream

Interface
REQ-001 Parameter AXI_DATA_WIDTH, default 8, sets the stream data width; legal values are 8, 16, 32 and 64.
REQ-002 Parameter KEEP_WIDTH, default AXI_DATA_WIDTH/8, sets the byte-enable width.
REQ-003 Parameter PORT_FILTER, default 0; when 1, packets whose destination port differs from i_local_port are dropped.
REQ-004 Port i_clk, input, 1, is the single clock; all logic is rising-edge.
REQ-005 Port i_reset, input, 1, is a synchronous, active-high reset.
REQ-006 Ports s_axis_tdata/tkeep/tvalid/tlast (in, AXI_DATA_WIDTH/KEEP_WIDTH/1/1) and s_axis_trdy (out, 1) carry the encapsulated UDP packet from IP.
REQ-007 Ports m_axis_tdata/tkeep/tvalid/tlast/tuser (out, AXI_DATA_WIDTH/KEEP_WIDTH/1/1/1) and m_axis_trdy (in, 1) carry the de-encapsulated payload.
REQ-008 Ports m_udp_hdr_tvalid (out, 1), m_udp_hdr_trdy (in, 1), m_udp_src_port, m_udp_dst_port, m_udp_length and m_udp_checksum (out, 16 each) carry the parsed header.
REQ-009 Port i_local_port, input, 16, is the destination-port match value and is sampled only when the header completes.
REQ-010 Ports o_err_truncated and o_err_length, output, 1 each, are single-cycle error pulses.

Function
REQ-011 Byte order: byte 0 of each beat is in lane [7:0]; 16-bit header fields are big-endian, so each field = {byte n, byte n+1}.
REQ-012 The header occupies HDR_BEATS = 64/AXI_DATA_WIDTH beats, which are assumed to have all tkeep bits set.
REQ-013 The state machine has states HDR, PAYLOAD and DROP; reset enters HDR with the beat counter at 0.
REQ-014 In HDR, s_axis_trdy = !m_udp_hdr_tvalid, so a new header is not accepted while the previous header is unacknowledged.
REQ-015 In HDR, each accepted beat writes its header bytes into the field registers and increments the counter.
REQ-016 On the final header beat: if tlast=0 and the filter passes, assert m_udp_hdr_tvalid on the next cycle and go to PAYLOAD.
REQ-017 On the final header beat: if the filter fails, go to DROP with no header output.
REQ-018 On the final header beat: if tlast=1 (zero-length payload), emit the header, stay in HDR, and pulse o_err_length when m_udp_length != 8.
REQ-019 tlast on a non-final header beat: pulse o_err_truncated on the next cycle, emit no header, reset the counter, and stay in HDR.
REQ-020 m_udp_hdr_tvalid stays high until m_udp_hdr_trdy is sampled high, and the field outputs are stable while it is high.
REQ-021 The payload path is a single output register; in PAYLOAD, s_axis_trdy = !m_axis_tvalid || m_axis_trdy.
REQ-022 An accepted input beat appears on m_axis one cycle later, with tdata, tkeep and tlast copied unchanged.
REQ-023 The payload flows independently of header acknowledgement.
REQ-024 m_axis_tvalid and all m_axis data stay stable until m_axis_trdy is sampled high; no beat is lost or duplicated.
REQ-025 A 16-bit payload byte counter adds popcount(tkeep) per accepted beat (tkeep is contiguous from lane 0) and wraps mod 2^16.
REQ-026 On the tlast beat, compute the total including that beat; m_axis_tuser=1 on the output tlast beat if total != m_udp_length-8.
REQ-027 The same mismatch condition, including m_udp_length < 8, pulses o_err_length one cycle after tlast is accepted; m_axis_tuser=0 on all other beats.
REQ-028 After the tlast beat is accepted in PAYLOAD, return to HDR; the next header beat may be accepted on the following cycle.
REQ-029 In DROP, s_axis_trdy=1, m_axis is not written, and the state returns to HDR after tlast is accepted.
REQ-030 Simultaneous output acceptance and new input acceptance in PAYLOAD give full throughput of one beat per cycle.

Reset
REQ-031 Reset forces state=HDR, counters=0, and m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_udp_hdr_tvalid, o_err_truncated and o_err_length to 0.
REQ-032 Reset forces s_axis_trdy=1 from the first cycle after reset.
REQ-033 Header field registers reset to 0; m_axis_tdata and m_axis_tkeep reset to 0.
REQ-034 Reset mid-packet discards the packet; the next beat after reset is parsed as header byte 0.

Verification
REQ-035 Scenario (W=8): header 1234 5678 000C ABCD followed by 4 bytes -> header outputs 0x1234/0x5678/0x000C/0xABCD, 4 payload beats, tuser=0, no error pulses.
REQ-036 Scenario (W=32): header words with length 0x000D and 5 payload bytes, last beat tkeep=0x1 -> 2 output beats, last tkeep=0x1, tuser=0.
REQ-037 Scenario: length=0x0010 but 6 payload bytes sent -> tuser=1 on the last output beat and one o_err_length pulse.
REQ-038 Scenario (PORT_FILTER=1, i_local_port=0x5678): dst=0x1111 -> entire packet consumed, no header or payload output; the next matching packet passes.
REQ-039 Scenario: tlast on header byte 5 (W=8) -> one o_err_truncated pulse, no header output, and the following packet parses correctly.
REQ-040 Scenario: random m_axis_trdy and m_udp_hdr_trdy back-pressure with back-to-back packets -> payload bytes match the reference, and the second header is not accepted until the first is acknowledged.
